// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data-memory responder and the core's
// decode/load-store path.
//   - size encodings SZ_B / SZ_H / SZ_W (size 2'd3 is illegal)
//   - FSM state type for the responder
//   - request payload struct
//   - alignment / size legality helpers
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [1:0]      size;
        logic            uns;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // Halves need addr[0] = 0, words need addr[1:0] = 0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
    endfunction

    function automatic logic is_illegal_size(input logic [1:0] size);
        return (size == 2'd3);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request channel plus response channel between the core
// (master) and the data-memory responder (slave).
//   req_*  : request handshake and payload, driven by the master
//   rsp_*  : response handshake and payload, driven by the slave (rsp_ready by master)
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_align.sv
// dmem_align: combinational lane steering for little-endian sub-word access.
//   size, addr_lo, uns : access size, byte offset in word, zero-extend select
//   wdata              : right-aligned store data
//   rword              : word read from the array
//   be_c, wdata_c      : store byte enables and lane-replicated store data
//   rdata_c            : extracted and sign/zero-extended load data
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Store lanes: replicate data so the enabled lanes always see the right bytes.
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = 32'h0;
        case (size)
            SZ_B: begin
                be_c    = 4'b0001 << addr_lo;
                wdata_c = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
            end
            SZ_W: begin
                be_c    = 4'b1111;
                wdata_c = wdata;
            end
            default: begin
                be_c    = 4'b0000;
                wdata_c = 32'h0;
            end
        endcase
    end

    // Load lanes: shift the addressed lane down, then extend.
    always_comb begin
        rbyte   = 8'(rword >> {addr_lo, 3'b000});
        rhalf   = 16'(rword >> {addr_lo[1], 4'b0000});
        rdata_c = 32'h0;
        case (size)
            SZ_B:    rdata_c = uns ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            SZ_H:    rdata_c = uns ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            SZ_W:    rdata_c = rword;
            default: rdata_c = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the CPU data-memory load/store interface.
// One request at a time; byte/half/word access to a word-organised RAM;
// response returned READ_LAT cycles after acceptance and held until taken.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : dmem_if slave modport (request + response channels)
// Parameters: DEPTH (words), READ_LAT (1..15).
// Optional: define DMEM_BOUNDS_CHECK_EN to flag word indices >= DEPTH as
// errors instead of wrapping them modulo DEPTH.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned READ_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WIDX_W = 30;
    localparam int unsigned CNT_W  = 4;

    logic [31:0] mem [DEPTH];

    state_t      state;
    logic [CNT_W-1:0] cnt;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] pend_rdata;
    logic        pend_err;

    dmem_req_t   req_c;
    logic [WIDX_W-1:0] widx_c;
    logic [IDX_W-1:0]  idx_c;
    logic        oob_c;
    logic        err_c;
    logic        accept_c;
    logic        wr_en_c;
    logic [31:0] rword_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ext_c;
    logic [31:0] res_rdata_c;

    assign req_c = '{
        we:    bus.req_we,
        addr:  bus.req_addr,
        size:  bus.req_size,
        uns:   bus.req_unsigned,
        wdata: bus.req_wdata
    };

    assign widx_c = req_c.addr[31:2];

    // Word index: range-checked or wrapped modulo DEPTH.
`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob_c = (widx_c >= WIDX_W'(DEPTH));
    assign idx_c = oob_c ? '0 : IDX_W'(widx_c);
`else
    localparam logic [WIDX_W-1:0] IDX_MASK = WIDX_W'(DEPTH - 1);
    assign oob_c = 1'b0;
    assign idx_c = IDX_W'(widx_c & IDX_MASK);
`endif

    assign err_c    = is_misaligned(req_c.size, req_c.addr[1:0]) || is_illegal_size(req_c.size) || oob_c;
    assign accept_c = bus.req_valid && req_ready_q;
    assign wr_en_c  = accept_c && req_c.we && !err_c && !rst;
    assign rword_c  = mem[idx_c];

    dmem_align u_align (
        .size    (req_c.size),
        .addr_lo (req_c.addr[1:0]),
        .uns     (req_c.uns),
        .wdata   (req_c.wdata),
        .rword   (rword_c),
        .be_c    (be_c),
        .wdata_c (wdata_c),
        .rdata_c (ext_c)
    );

    // Stores and errors return zero data.
    assign res_rdata_c = (req_c.we || err_c) ? 32'h0 : ext_c;

    // RAM write commits at the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with latency counter and registered channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            pend_rdata  <= 32'h0;
            pend_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        req_ready_q <= 1'b0;
                        if (READ_LAT == 1) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= res_rdata_c;
                            rsp_err_q   <= err_c;
                        end else begin
                            state      <= BUSY;
                            cnt        <= CNT_W'(READ_LAT - 2);
                            pend_rdata <= res_rdata_c;
                            pend_err   <= err_c;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pend_rdata;
                        rsp_err_q   <= pend_err;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (slave) end of the CPU data-memory load/store interface.
- Accepts one request at a time from the core's load/store path over a valid/ready handshake.
- Performs byte, half-word or word reads and writes on an internal word-organised RAM. Addresses are little-endian.
- Returns read data, or a write acknowledge, over a separate valid/ready response channel after a configurable latency.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array; must be a power of two unless DMEM_BOUNDS_CHECK_EN is defined.
- READ_LAT, 1, cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  misaligned access, illegal size, or out-of-range address (feature-dependent).

Behaviour:
- Reset: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0. RAM contents are not cleared.
- A request is accepted on a cycle where req_valid && req_ready (cycle T). All request fields are captured at T.
- FSM states:
  - IDLE: req_ready = 1. On acceptance, go to RESP if READ_LAT == 1; otherwise go to BUSY with cnt = READ_LAT-2.
  - BUSY: req_ready = 0. Decrement cnt each cycle; when cnt == 0, go to RESP.
  - RESP: rsp_valid = 1, req_ready = 0. When rsp_ready, go to IDLE.
- Timing:
  - rsp_valid first rises at T+READ_LAT.
  - rsp_valid, rsp_rdata and rsp_err are held stable until the handshake completes.
  - Maximum throughput is one transaction per READ_LAT+1 cycles.
- Stores:
  - The RAM write occurs at edge T, using byte enables derived from size and addr[1:0].
  - Byte lane = addr[1:0]; half lane = addr[1].
  - The response is an acknowledge with rdata = 0.
- Loads:
  - The word is read at T. For READ_LAT > 1 the result passes through a READ_LAT-deep pipeline or hold register.
  - A store accepted earlier is always visible to a later load, since only one request is outstanding.
  - Lane selection follows the same addr[1:0] rules as stores, then the result is extended per req_unsigned.
- Errors:
  - Conditions: half with addr[0] = 1; word with addr[1:0] != 0; size = 3.
  - On error: no RAM write, rsp_err = 1, rdata = 0, same latency as a good access.
- Address bits above the word index are ignored unless DMEM_BOUNDS_CHECK_EN is defined.
- Reset mid-transaction (in BUSY or RESP): the pending response is dropped and the FSM returns to IDLE on the next edge. A store already committed at T stays written.
- rsp_ready asserted outside RESP is ignored. req_valid asserted while req_ready = 0 is ignored; the requester must hold its request.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: a word index addr[31:2] >= DEPTH is an error (rsp_err = 1, no write, rdata = 0). DEPTH may be any value >= 1.
- Undefined: the index wraps modulo DEPTH using the low $clog2(DEPTH) bits of addr[31:2]. Out-of-range addresses alias into the array.

Decomposition:
- Shared package dmem_pkg holds:
  - size encoding constants SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2.
  - FSM state typedef with IDLE, BUSY, RESP.
  - function for misalignment detection.
  - The package is shared with the core's decode/load-store path.
- Sub-module dmem_align (combinational) contains:
  - store byte-enable generation and lane replication of wdata.
  - load lane extraction and sign/zero extension.
- The FSM, latency counter and RAM stay in dmem_responder.

Test Plan:
- READ_LAT = 1: store word 0xDEADBEEF at 0x10, then load word from 0x10 → rsp_valid at T+1, rdata = 0xDEADBEEF, err = 0.
- Byte loads from 0x13 after the store above: signed → 0xFFFFFFDE; unsigned → 0x000000DE. Store half 0x1234 at 0x12, then load word 0x10 → 0x1234BEEF.
- Misaligned accesses:
  - Load word at 0x11 → err = 1, rdata = 0.
  - Store half 0xAAAA at 0x13 → err = 1; a subsequent word load at 0x10 is unchanged.
  - size = 3 → err = 1.
- READ_LAT = 4 with rsp_ready held low 3 extra cycles:
  - rsp_valid rises at T+4 and the response stays stable for 4 cycles.
  - req_ready stays 0 until the cycle after the rsp handshake.
  - A new req_valid held during BUSY is not accepted.
- Reset asserted in BUSY with READ_LAT = 3 → next cycle: rsp_valid = 0, req_ready = 1, no stale response appears afterwards.
- DEPTH = 16:
  - Without the macro, a store to 0x40 and a load from 0x00 return the same word (wrap).
  - With DMEM_BOUNDS_CHECK_EN, the store to 0x40 → err = 1 and word 0 is unchanged.
